spi_sha_bridge: RTL and testbench



---
 rtl/spi_sha_pkg.sv | 27 ++
 rtl/spi_word_event.sv | 29 ++
 rtl/spi_sha_bridge.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_sha_bridge.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/spi_sha_pkg.sv
// Shared constants, FSM encoding and word helpers for the SPI-to-SHA-256 bridge.
package spi_sha_pkg;

  localparam logic [3:0] OP_LOAD_FIRST  = 4'h1;
  localparam logic [3:0] OP_LOAD_NEXT   = 4'h2;
  localparam logic [3:0] OP_READ_DIGEST = 4'h3;
  localparam logic [3:0] STATUS_MAGIC   = 4'hA;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    BUSY  = 3'd3,
    DUMP  = 3'd4
  } state_t;

  // Digest word 0 is the most significant 16 bits; {~idx, 4'hF} is its top bit index.
  function automatic logic [15:0] digest_word(input logic [255:0] digest, input logic [3:0] idx);
    return digest[{~idx, 4'hF} -: 16];
  endfunction

  function automatic logic [15:0] status_word(input logic dv, input logic err, input logic busy,
                                              input logic [8:0] cnt);
    return {STATUS_MAGIC, dv, err, busy, cnt};
  endfunction

endpackage

// File: rtl/spi_word_event.sv
// Edge detector turning the SPI slave word-done level and slave select into one-cycle pulses.
module spi_word_event (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ss,
  input  logic i_word_done,
  output logic o_word_evt,
  output logic o_ss_rise
);

  logic word_done_r;
  logic ss_r;

  // Previous-cycle copies of the slave handshake lines.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      word_done_r <= 1'b0;
      ss_r        <= 1'b1;
    end else begin
      word_done_r <= i_word_done;
      ss_r        <= i_ss;
    end
  end

  // The word is still stable in the fall cycle, so the event fires combinationally there.
  assign o_word_evt = word_done_r & ~i_word_done;
  assign o_ss_rise  = i_ss & ~ss_r;

endmodule

// File: rtl/spi_sha_bridge.sv
// Assembles SPI words into 512-bit SHA-256 blocks, launches the core and streams status/digest back.
module spi_sha_bridge
  import spi_sha_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_ss,
  input  logic         i_word_done,
  input  logic [15:0]  i_word,
  output logic [15:0]  o_tx_data,
  input  logic         i_sha_ready,
  output logic         o_sha_start,
  output logic         o_sha_init,
  output logic [511:0] o_sha_block,
  input  logic         i_sha_valid,
  input  logic [255:0] i_sha_digest,
  output logic         o_err
);

  logic word_evt_s;
  logic ss_rise_s;

  spi_word_event u_word_event (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_ss        (i_ss),
    .i_word_done (i_word_done),
    .o_word_evt  (word_evt_s),
    .o_ss_rise   (ss_rise_s)
  );

  state_t         state_r;
  logic [4:0]     wr_idx_r;
  logic [3:0]     tx_idx_r;
  logic           dv_r;
  logic [8:0]     cnt_r;
  logic [255:0]   digest_r;
  logic [15:0]    blk_r [32];

  state_t         state_s;
  logic [4:0]     wr_idx_s;
  logic [3:0]     tx_idx_s;
  logic           dv_s;
  logic [8:0]     cnt_s;
  logic           err_s;
  logic           start_s;
  logic           init_s;
  logic           blk_we_s;
  logic           dig_we_s;
  logic           busy_s;
  logic [15:0]    tx_s;
  logic [3:0]     opcode_s;

  assign opcode_s = i_word[15:12];

  // Next-state decode: word handling first, deselect abort applied last so it wins.
  always_comb begin
    state_s  = state_r;
    wr_idx_s = wr_idx_r;
    tx_idx_s = tx_idx_r;
    dv_s     = dv_r;
    cnt_s    = cnt_r;
    err_s    = o_err;
    init_s   = o_sha_init;
    start_s  = 1'b0;
    blk_we_s = 1'b0;
    dig_we_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (word_evt_s) begin
          case (opcode_s)
            OP_LOAD_FIRST: begin
              state_s  = LOAD;
              wr_idx_s = 5'd0;
              dv_s     = 1'b0;
              init_s   = 1'b1;
            end
            OP_LOAD_NEXT: begin
              if (dv_r) begin
                state_s  = LOAD;
                wr_idx_s = 5'd0;
                dv_s     = 1'b0;
                init_s   = 1'b0;
              end else begin
                err_s = 1'b1;
              end
            end
            OP_READ_DIGEST: begin
              if (dv_r) begin
                state_s  = DUMP;
                tx_idx_s = 4'd0;
              end else begin
                err_s = 1'b1;
              end
            end
            default: err_s = 1'b1;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (word_evt_s) begin
          blk_we_s = 1'b1;
          if (wr_idx_r == 5'd31) begin
            // Launch straight from the last word so start lands in the very next cycle.
            if (i_sha_ready) begin
              start_s = 1'b1;
              state_s = BUSY;
            end else begin
              state_s = START;
            end
          end else begin
            wr_idx_s = wr_idx_r + 5'd1;
          end
        end else begin
          state_s = LOAD;
        end
      end
      START: begin
        if (i_sha_ready) begin
          start_s = 1'b1;
          state_s = BUSY;
        end else begin
          state_s = START;
        end
        if (word_evt_s) begin
          err_s = 1'b1;
        end else begin
          err_s = o_err;
        end
      end
      BUSY: begin
        if (i_sha_valid) begin
          dig_we_s = 1'b1;
          dv_s     = 1'b1;
          cnt_s    = cnt_r + 9'd1;
          state_s  = IDLE;
        end else begin
          state_s = BUSY;
        end
        if (word_evt_s) begin
          err_s = 1'b1;
        end else begin
          err_s = o_err;
        end
      end
      DUMP: begin
        if (word_evt_s) begin
          if (tx_idx_r == 4'd15) begin
            state_s = IDLE;
          end else begin
            tx_idx_s = tx_idx_r + 4'd1;
          end
        end else begin
          state_s = DUMP;
        end
      end
      default: state_s = IDLE;
    endcase

    if (ss_rise_s && ((state_r == LOAD) || (state_r == DUMP))) begin
      state_s = IDLE;
      err_s   = 1'b1;
      start_s = 1'b0;
    end else begin
      state_s = state_s;
    end
  end

  // Transmit word is derived from the next-cycle state so it updates right after the event.
  always_comb begin
    busy_s = (state_s == START) || (state_s == BUSY);
    if (state_s == DUMP) begin
      tx_s = digest_word(digest_r, tx_idx_s);
    end else begin
      tx_s = status_word(dv_s, err_s, busy_s, cnt_s);
    end
  end

  // State, control and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= IDLE;
      wr_idx_r    <= 5'd0;
      tx_idx_r    <= 4'd0;
      dv_r        <= 1'b0;
      cnt_r       <= 9'd0;
      digest_r    <= 256'd0;
      o_err       <= 1'b0;
      o_sha_start <= 1'b0;
      o_sha_init  <= 1'b0;
      o_tx_data   <= 16'hA000;
      for (int i = 0; i < 32; i++) begin
        blk_r[i] <= 16'h0000;
      end
    end else begin
      state_r     <= state_s;
      wr_idx_r    <= wr_idx_s;
      tx_idx_r    <= tx_idx_s;
      dv_r        <= dv_s;
      cnt_r       <= cnt_s;
      o_err       <= err_s;
      o_sha_start <= start_s;
      o_sha_init  <= init_s;
      o_tx_data   <= tx_s;
      if (dig_we_s) begin
        digest_r <= i_sha_digest;
      end
      if (blk_we_s) begin
        blk_r[wr_idx_r] <= i_word;
      end
    end
  end

  for (genvar g = 0; g < 32; g++) begin : g_flat
    assign o_sha_block[511 - 16*g -: 16] = blk_r[g];
  end

endmodule

// File: tb/tb_spi_sha_bridge.sv
// Self-checking bench for spi_sha_bridge with a behavioural SHA core stand-in and scoreboards.
module tb_spi_sha_bridge;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_ss;
  logic         i_word_done;
  logic [15:0]  i_word;
  logic [15:0]  o_tx_data;
  logic         i_sha_ready;
  logic         o_sha_start;
  logic         o_sha_init;
  logic [511:0] o_sha_block;
  logic         i_sha_valid = 1'b0;
  logic [255:0] i_sha_digest;
  logic         o_err;

  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  spi_sha_bridge dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ss(i_ss), .i_word_done(i_word_done), .i_word(i_word),
    .o_tx_data(o_tx_data), .i_sha_ready(i_sha_ready), .o_sha_start(o_sha_start),
    .o_sha_init(o_sha_init), .o_sha_block(o_sha_block), .i_sha_valid(i_sha_valid),
    .i_sha_digest(i_sha_digest), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [511:0] blk; logic init; } job_t;
  typedef struct { logic [15:0] word; logic [15:0] exp_tx; } vec_t;

  job_t        job_q[$];
  logic [15:0] tx_q[$];
  job_t        cur_job;
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_evt_cyc = 0;
  int exp_start_cyc = -1;
  int start_cnt = 0;
  int timer = 0;
  logic prev_start = 1'b0;
  logic [511:0] abc_blk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // SHA core stand-in: checks each start against the scoreboard and answers after a fixed latency.
  always @(negedge i_clk) begin
    i_sha_valid = 1'b0;
    if (timer > 0) begin
      timer--;
      if (timer == 0) begin
        i_sha_valid = 1'b1;
        check("block_stable", {o_sha_block, 511'd0, o_sha_init}, {cur_job.blk, 511'd0, cur_job.init});
      end
    end
    if (o_sha_start) begin
      start_cnt++;
      check("start_one_cycle", {511'd0, prev_start}, 512'd0);
      if (job_q.size() == 0) begin
        check("unexpected_start", 512'd1, 512'd0);
      end else begin
        cur_job = job_q.pop_front();
        check("start_block", o_sha_block, cur_job.blk);
        check("start_init", {511'd0, o_sha_init}, {511'd0, cur_job.init});
        if (exp_start_cyc >= 0) check("start_cycle", 512'(cyc), 512'(exp_start_cyc));
        exp_start_cyc = -1;
      end
      timer = 8;
    end
    prev_start = o_sha_start;
  end

  task automatic do_reset();
    i_rst = 1'b1; i_ss = 1'b0; i_word_done = 1'b0; i_word = 16'h0000; i_sha_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    @(posedge i_clk); #1; i_word = w; i_word_done = 1'b1;
    @(posedge i_clk); #1; i_word_done = 1'b0;
    @(posedge i_clk); #1; last_evt_cyc = cyc;
  endtask

  task automatic word_chk(input logic [15:0] w, input logic [15:0] exp, input string name);
    tx_q.push_back(exp);
    send_word(w);
    check(name, {496'd0, o_tx_data}, {496'd0, tx_q.pop_front()});
  endtask

  task automatic load_block(input logic [15:0] cmd, input logic init, input logic [511:0] blk);
    logic [511:0] b;
    job_t j;
    j.blk = blk; j.init = init;
    job_q.push_back(j);
    b = blk;
    send_word(cmd);
    for (int i = 0; i < 32; i++) begin
      send_word(b[511 -: 16]);
      b = b << 16;
    end
    if (i_sha_ready) exp_start_cyc = last_evt_cyc;
  endtask

  task automatic wait_status(input logic [15:0] exp, input string name);
    for (int i = 0; i < 100 && o_tx_data !== exp; i++) @(posedge i_clk);
    #1 check(name, {496'd0, o_tx_data}, {496'd0, exp});
  endtask

  initial begin
    vec_t dump_tab[17];
    vec_t err_tab[4];
    int s0;
    i_sha_digest = ABC_DIG;
    abc_blk = {32'h61626380, 448'd0, 32'h00000018};
    dump_tab[0]  = '{16'h3000, 16'hba78};
    dump_tab[1]  = '{16'h1111, 16'h16bf};  dump_tab[2]  = '{16'h2222, 16'h8f01};
    dump_tab[3]  = '{16'h0000, 16'hcfea};  dump_tab[4]  = '{16'hFFFF, 16'h4141};
    dump_tab[5]  = '{16'h1234, 16'h40de};  dump_tab[6]  = '{16'h3000, 16'h5dae};
    dump_tab[7]  = '{16'h0001, 16'h2223};  dump_tab[8]  = '{16'h8000, 16'hb003};
    dump_tab[9]  = '{16'h0000, 16'h61a3};  dump_tab[10] = '{16'h0000, 16'h9617};
    dump_tab[11] = '{16'h0000, 16'h7a9c};  dump_tab[12] = '{16'h0000, 16'hb410};
    dump_tab[13] = '{16'h0000, 16'hff61};  dump_tab[14] = '{16'h0000, 16'hf200};
    dump_tab[15] = '{16'h0000, 16'h15ad};  dump_tab[16] = '{16'h0000, 16'hA801};
    err_tab[0] = '{16'h2000, 16'hA400};    err_tab[1] = '{16'h3FFF, 16'hA400};
    err_tab[2] = '{16'h0000, 16'hA400};    err_tab[3] = '{16'hF123, 16'hA400};

    // Reset state and quiet idle.
    do_reset();
    check("rst_tx", {496'd0, o_tx_data}, {496'd0, 16'hA000});
    check("rst_err", {511'd0, o_err}, 512'd0);
    check("rst_init", {511'd0, o_sha_init}, 512'd0);
    check("rst_block", o_sha_block, 512'd0);
    repeat (5) @(posedge i_clk);
    #1 check("idle_no_start", 512'(start_cnt), 512'd0);

    // "abc" block, core ready.
    load_block(16'h1000, 1'b1, abc_blk);
    check("busy_status", {496'd0, o_tx_data}, {496'd0, 16'hA200});
    wait_status(16'hA801, "abc_done_status");
    check("abc_err", {511'd0, o_err}, 512'd0);

    // Digest readback.
    for (int k = 0; k < 17; k++) word_chk(dump_tab[k].word, dump_tab[k].exp_tx, $sformatf("dump%0d", k));

    // Illegal commands after reset.
    do_reset();
    s0 = start_cnt;
    for (int k = 0; k < 4; k++) word_chk(err_tab[k].word, err_tab[k].exp_tx, $sformatf("illegal%0d", k));
    check("illegal_err", {511'd0, o_err}, 512'd1);
    repeat (3) @(posedge i_clk);
    #1 check("illegal_no_start", 512'(start_cnt), 512'(s0));

    // Deselect abort after 10 data words, then a clean block.
    do_reset();
    s0 = start_cnt;
    send_word(16'h1000);
    for (int i = 0; i < 10; i++) send_word(16'h1000 + 16'(i));
    @(posedge i_clk); #1 i_ss = 1'b1;
    @(posedge i_clk); #1 i_ss = 1'b0;
    @(posedge i_clk); #1;
    check("abort_status", {496'd0, o_tx_data}, {496'd0, 16'hA400});
    repeat (20) @(posedge i_clk);
    #1 check("abort_no_start", 512'(start_cnt), 512'(s0));
    load_block(16'h1000, 1'b1, abc_blk);
    wait_status(16'hAC01, "after_abort_status");

    // Core not ready for 5 cycles, then a word arrives while busy.
    do_reset();
    i_sha_ready = 1'b0;
    s0 = start_cnt;
    load_block(16'h1000, 1'b1, abc_blk);
    check("start_wait_status", {496'd0, o_tx_data}, {496'd0, 16'hA200});
    repeat (5) @(posedge i_clk);
    #1 check("held_no_start", 512'(start_cnt), 512'(s0));
    exp_start_cyc = cyc + 1;
    i_sha_ready = 1'b1;
    send_word(16'h4444);
    check("busy_word_err", {496'd0, o_tx_data}, {496'd0, 16'hA600});
    wait_status(16'hAC01, "delayed_done_status");

    check("total_starts", 512'(start_cnt), 512'd3);
    check("jobs_drained", 512'(job_q.size()), 512'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
